// File: rtl/seq_detect_param_if.sv
// Bus interface for seq_detect_param: configuration, serial input stream and detector outputs.
// The counter signals (cnt_clr, match_cnt) exist only when SEQ_DET_CNT_EN is defined.
interface seq_detect_param_if #(
  parameter int unsigned MAX_LEN = 8
`ifdef SEQ_DET_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               enable;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din_in;
  logic               match;
  logic               cfg_err;
  logic [1:0]         state_o;
`ifdef SEQ_DET_CNT_EN
  logic               cnt_clr;
  logic [CNT_W-1:0]   match_cnt;
`endif

  // Stimulus side: drives config and stream, observes detector outputs
  modport master (
    output enable, cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din_in,
    input  match, cfg_err, state_o
`ifdef SEQ_DET_CNT_EN
    , output cnt_clr
    , input  match_cnt
`endif
  );

  // Detector side
  modport slave (
    input  enable, cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din_in,
    output match, cfg_err, state_o
`ifdef SEQ_DET_CNT_EN
    , input  cnt_clr
    , output match_cnt
`endif
  );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial sequence detector.
// Pattern (1..MAX_LEN bits, last-received bit in pattern[0]), length and overlap mode are
// loaded with cfg_load. Each hit gives a registered one-cycle match pulse.
// Optional feature: define SEQ_DET_CNT_EN to add a saturating hit counter (cnt_clr/match_cnt).
module seq_detect_param #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1101),
  parameter int unsigned        RST_LEN     = 4,
  parameter logic               RST_OVERLAP = 1'b1
`ifdef SEQ_DET_CNT_EN
  , parameter int unsigned      CNT_W       = 16
`endif
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  seq_detect_param_if.slave   bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_HUNT = 2'b10
  } state_t;

  state_t             state_q, state_nx;
  // Only the previous MAX_LEN-1 bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_q, hist_nx;
  logic [LEN_W-1:0]   fill_q, fill_nx;
  logic [MAX_LEN-1:0] pat_q, pat_nx;
  logic [LEN_W-1:0]   len_q, len_nx;
  logic               ovl_q, ovl_nx;
  logic               match_q, match_nx;
  logic               err_q, err_nx;

  logic [MAX_LEN-1:0] win_c;
  logic [MAX_LEN-1:0] mask_c;
  logic               hit_c;
  logic               cfg_ok_c;
  logic               fill_last_c;

  // Compare window: stored history plus the bit on din_in, masked to the active length
  always_comb begin
    win_c = {hist_q, bus.din_in};
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (LEN_W'(i) < len_q);
    end
    hit_c       = (((win_c ^ pat_q) & mask_c) == '0);
    cfg_ok_c    = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    fill_last_c = ((fill_q + LEN_W'(1)) == len_q);
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_nx = state_q;
    hist_nx  = hist_q;
    fill_nx  = fill_q;
    pat_nx   = pat_q;
    len_nx   = len_q;
    ovl_nx   = ovl_q;
    match_nx = 1'b0;
    err_nx   = 1'b0;

    if (bus.cfg_load && cfg_ok_c) begin
      // Accepted reconfiguration restarts detection; any same-cycle data bit is dropped
      pat_nx   = bus.cfg_pattern;
      len_nx   = bus.cfg_len;
      ovl_nx   = bus.cfg_overlap;
      hist_nx  = '0;
      fill_nx  = '0;
      state_nx = bus.enable ? ST_FILL : ST_IDLE;
    end else begin
      err_nx = bus.cfg_load;
      if (!bus.enable) begin
        state_nx = ST_IDLE;
        hist_nx  = '0;
        fill_nx  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_nx = ST_FILL;
          end
          ST_FILL: begin
            if (bus.din_valid) begin
              if (fill_last_c) begin
                match_nx = hit_c;
                if (hit_c && !ovl_q) begin
                  hist_nx = '0;
                  fill_nx = '0;
                end else begin
                  hist_nx  = win_c[MAX_LEN-2:0];
                  state_nx = ST_HUNT;
                end
              end else begin
                hist_nx = win_c[MAX_LEN-2:0];
                fill_nx = fill_q + LEN_W'(1);
              end
            end
          end
          ST_HUNT: begin
            if (bus.din_valid) begin
              match_nx = hit_c;
              if (hit_c && !ovl_q) begin
                hist_nx  = '0;
                fill_nx  = '0;
                state_nx = ST_FILL;
              end else begin
                hist_nx = win_c[MAX_LEN-2:0];
              end
            end
          end
          default: begin
            state_nx = ST_IDLE;
            hist_nx  = '0;
            fill_nx  = '0;
          end
        endcase
      end
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Datapath, configuration and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PATTERN;
      len_q   <= LEN_W'(RST_LEN);
      ovl_q   <= RST_OVERLAP;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      hist_q  <= hist_nx;
      fill_q  <= fill_nx;
      pat_q   <= pat_nx;
      len_q   <= len_nx;
      ovl_q   <= ovl_nx;
      match_q <= match_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.match   = match_q;
  assign bus.cfg_err = err_q;
  assign bus.state_o = state_q;

`ifdef SEQ_DET_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_q;

  // Saturating hit counter; a clear coinciding with a hit leaves a count of one
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= match_nx ? CNT_W'(1) : '0;
    end else if (match_nx && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: directed scenarios plus randomized traffic against a
// bit-queue reference model of the detector.
module tb_seq_detect_param;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
`ifdef SEQ_DET_CNT_EN
  localparam int unsigned CNT_W   = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_detect_param_if #(
    .MAX_LEN(MAX_LEN)
`ifdef SEQ_DET_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();

  seq_detect_param #(
    .MAX_LEN(MAX_LEN)
`ifdef SEQ_DET_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of bits accepted since the last history clear
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 m_active;
  bit                 m_q[$];
  bit                 exp_match;
  bit                 exp_err;
  logic [1:0]         exp_state;
`ifdef SEQ_DET_CNT_EN
  int                 m_cnt;
`endif

  function automatic void model_reset();
    m_pat     = 8'b0000_1101;
    m_len     = 4;
    m_ovl     = 1'b1;
    m_active  = 1'b0;
    m_q.delete();
    exp_match = 1'b0;
    exp_err   = 1'b0;
    exp_state = 2'b00;
`ifdef SEQ_DET_CNT_EN
    m_cnt     = 0;
`endif
  endfunction

  // Advance the model by one clock using the inputs presented at this edge
  function automatic void model_step();
    bit legal;
    bit hit;
    hit       = 1'b0;
    exp_match = 1'b0;
    exp_err   = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    legal = bus.cfg_load && (int'(bus.cfg_len) >= 1) && (int'(bus.cfg_len) <= MAX_LEN);
    if (legal) begin
      m_pat    = bus.cfg_pattern;
      m_len    = int'(bus.cfg_len);
      m_ovl    = bus.cfg_overlap;
      m_active = bus.enable;
      m_q.delete();
    end else begin
      exp_err = bus.cfg_load;
      if (!bus.enable) begin
        m_active = 1'b0;
        m_q.delete();
      end else if (!m_active) begin
        m_active = 1'b1;
      end else if (bus.din_valid) begin
        m_q.push_back(bus.din_in);
        if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        if (m_q.size() >= m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
        end
        if (hit) begin
          exp_match = 1'b1;
          if (!m_ovl) m_q.delete();
        end
      end
    end
`ifdef SEQ_DET_CNT_EN
    if (bus.cnt_clr) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
    exp_state = !m_active ? 2'b00 : ((m_q.size() < m_len) ? 2'b01 : 2'b10);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet_inputs();
    bus.cfg_load  = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_in    = 1'b0;
`ifdef SEQ_DET_CNT_EN
    bus.cnt_clr   = 1'b0;
`endif
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_overlap = ovl;
    tick();
    bus.cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL reset_match got %b exp 0", bus.match); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.cfg_err); end
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", bus.state_o); end
`ifdef SEQ_DET_CNT_EN
    checks++; if (bus.match_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.match_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL reset_idle got %b exp 00", bus.state_o); end
  endtask

  task automatic test_overlap();
    bit s[7] = '{1, 1, 0, 1, 1, 0, 1};
    int n = 0;
    bus.enable = 1'b1;
    tick();
    checks++; if (bus.state_o !== 2'b01) begin errors++; $display("FAIL ovl_fill got %b exp 01", bus.state_o); end
    for (int i = 0; i < 7; i++) begin
      bus.din_valid = 1'b1; bus.din_in = s[i];
      tick();
      bus.din_valid = 1'b0;
      if (bus.match === 1'b1) n++;
      checks++; if (bus.match !== exp_match) begin errors++; $display("FAIL ovl_match bit%0d got %b exp %b", i + 1, bus.match, exp_match); end
      checks++; if (bus.match !== bit'(i == 3 || i == 6)) begin errors++; $display("FAIL ovl_pos bit%0d got %b", i + 1, bus.match); end
      checks++; if (bus.state_o !== exp_state) begin errors++; $display("FAIL ovl_state bit%0d got %b exp %b", i + 1, bus.state_o, exp_state); end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL ovl_count got %0d exp 2", n); end
    checks++; if (bus.state_o !== 2'b10) begin errors++; $display("FAIL ovl_hunt got %b exp 10", bus.state_o); end
  endtask

  task automatic test_no_overlap();
    bit s[7] = '{1, 1, 0, 1, 1, 0, 1};
    int n = 0;
    load_cfg(8'h0D, 4, 1'b0);
    checks++; if (bus.state_o !== 2'b01) begin errors++; $display("FAIL novl_load got %b exp 01", bus.state_o); end
    for (int i = 0; i < 7; i++) begin
      bus.din_valid = 1'b1; bus.din_in = s[i];
      tick();
      bus.din_valid = 1'b0;
      if (bus.match === 1'b1) n++;
      checks++; if (bus.match !== exp_match) begin errors++; $display("FAIL novl_match bit%0d got %b exp %b", i + 1, bus.match, exp_match); end
      checks++; if (bus.state_o !== exp_state) begin errors++; $display("FAIL novl_state bit%0d got %b exp %b", i + 1, bus.state_o, exp_state); end
      if (i == 3) begin
        checks++; if (bus.state_o !== 2'b01) begin errors++; $display("FAIL novl_refill got %b exp 01", bus.state_o); end
      end
    end
    checks++; if (n != 1) begin errors++; $display("FAIL novl_count got %0d exp 1", n); end
  endtask

  task automatic test_cfg_err();
    int lens[2] = '{0, 9};
    bit s[4] = '{1, 1, 0, 1};
    int n = 0;
    for (int k = 0; k < 2; k++) begin
      bus.cfg_load = 1'b1; bus.cfg_len = LEN_W'(lens[k]); bus.cfg_pattern = 8'hFF;
      bus.cfg_overlap = 1'b1; bus.din_valid = 1'b1; bus.din_in = 1'b1;
      tick();
      quiet_inputs();
      checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse len%0d got %b exp 1", lens[k], bus.cfg_err); end
      checks++; if (bus.state_o !== exp_state) begin errors++; $display("FAIL err_state len%0d got %b exp %b", lens[k], bus.state_o, exp_state); end
      tick();
      checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL err_width len%0d got %b exp 0", lens[k], bus.cfg_err); end
    end
    bus.enable = 1'b0; tick();
    bus.enable = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      bus.din_valid = 1'b1; bus.din_in = s[i];
      tick();
      bus.din_valid = 1'b0;
      if (bus.match === 1'b1) n++;
      checks++; if (bus.match !== exp_match) begin errors++; $display("FAIL err_after bit%0d got %b exp %b", i + 1, bus.match, exp_match); end
    end
    checks++; if (n != 1) begin errors++; $display("FAIL err_keepcfg got %0d exp 1", n); end
  endtask

  task automatic test_gaps();
    logic [7:0] v = 8'hA5;
    int n = 0;
    load_cfg(8'hA5, 8, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        checks++; if (bus.match !== 1'b0 || exp_match) begin errors++; $display("FAIL gap_idle got %b exp 0", bus.match); end
      end
      bus.din_valid = 1'b1; bus.din_in = v[i];
      tick();
      bus.din_valid = 1'b0;
      if (bus.match === 1'b1) n++;
      checks++; if (bus.match !== exp_match) begin errors++; $display("FAIL gap_match bit%0d got %b exp %b", 8 - i, bus.match, exp_match); end
    end
    checks++; if (n != 1 || bus.match !== 1'b1) begin errors++; $display("FAIL gap_count got %0d last %b exp 1 1", n, bus.match); end
  endtask

  task automatic test_len1();
    for (int ovl = 0; ovl < 2; ovl++) begin
      int n = 0, ones = 0;
      load_cfg(8'h01, 1, bit'(ovl));
      for (int i = 0; i < 24; i++) begin
        bus.din_valid = ($urandom_range(0, 3) != 0);
        bus.din_in    = 1'($urandom_range(0, 1));
        if (bus.din_valid && bus.din_in) ones++;
        tick();
        if (bus.match === 1'b1) n++;
        checks++; if (bus.match !== exp_match) begin errors++; $display("FAIL len1_match ovl%0d i%0d got %b exp %b", ovl, i, bus.match, exp_match); end
      end
      quiet_inputs();
      checks++; if (n != ones) begin errors++; $display("FAIL len1_count ovl%0d got %0d exp %0d", ovl, n, ones); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      bus.cfg_load    = ($urandom_range(0, 29) == 0);
      bus.cfg_len     = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 9)) : LEN_W'($urandom_range(1, 3));
      bus.cfg_pattern = MAX_LEN'($urandom);
      bus.cfg_overlap = 1'($urandom_range(0, 1));
      if (bus.enable) bus.enable = ($urandom_range(0, 79) != 0);
      else            bus.enable = ($urandom_range(0, 3) == 0);
      bus.din_valid   = ($urandom_range(0, 9) < 7);
      bus.din_in      = 1'($urandom_range(0, 1));
`ifdef SEQ_DET_CNT_EN
      bus.cnt_clr     = ($urandom_range(0, 99) == 0);
`endif
      tick();
      checks++; if (bus.match !== exp_match) begin errors++; $display("FAIL rnd_match c%0d got %b exp %b", c, bus.match, exp_match); end
      checks++; if (bus.cfg_err !== exp_err) begin errors++; $display("FAIL rnd_err c%0d got %b exp %b", c, bus.cfg_err, exp_err); end
      checks++; if (bus.state_o !== exp_state) begin errors++; $display("FAIL rnd_state c%0d got %b exp %b", c, bus.state_o, exp_state); end
`ifdef SEQ_DET_CNT_EN
      checks++; if (int'(bus.match_cnt) != m_cnt) begin errors++; $display("FAIL rnd_cnt c%0d got %0d exp %0d", c, bus.match_cnt, m_cnt); end
`endif
    end
    quiet_inputs();
    bus.enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_midstream();
    bit s[4] = '{1, 1, 0, 1};
    int n = 0;
    load_cfg(8'h0D, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.din_valid = 1'b1; bus.din_in = s[i];
      tick();
    end
    bus.din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.match !== 1'b0 || bus.cfg_err !== 1'b0 || bus.state_o !== 2'b00) begin
        errors++; $display("FAIL rstmid_out k%0d got %b %b %b exp 0 0 00", k, bus.match, bus.cfg_err, bus.state_o);
      end
      if (k < 2) tick();
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.din_valid = 1'b1; bus.din_in = s[i];
      tick();
      bus.din_valid = 1'b0;
      if (bus.match === 1'b1) n++;
      checks++; if (bus.match !== exp_match || bus.match !== bit'(i == 3)) begin errors++; $display("FAIL rstmid_match bit%0d got %b exp %b", i + 1, bus.match, exp_match); end
    end
    checks++; if (n != 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", n); end
  endtask

`ifdef SEQ_DET_CNT_EN
  task automatic test_counter();
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    checks++; if (bus.match_cnt !== '0) begin errors++; $display("FAIL cnt_clr got %0d exp 0", bus.match_cnt); end
    load_cfg(8'h01, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.din_valid = 1'b1; bus.din_in = 1'b1;
      tick();
      checks++; if (int'(bus.match_cnt) != m_cnt) begin errors++; $display("FAIL cnt_step i%0d got %0d exp %0d", i, bus.match_cnt, m_cnt); end
    end
    bus.din_valid = 1'b0;
    checks++; if (bus.match_cnt !== 2'd3) begin errors++; $display("FAIL cnt_sat got %0d exp 3", bus.match_cnt); end
    bus.din_valid = 1'b1; bus.din_in = 1'b1; bus.cnt_clr = 1'b1;
    tick();
    quiet_inputs();
    checks++; if (bus.match_cnt !== 2'd1) begin errors++; $display("FAIL cnt_clr_hit got %0d exp 1", bus.match_cnt); end
  endtask
`endif

  initial begin
    bus.enable      = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    quiet_inputs();
    test_reset();
    test_overlap();
    test_no_overlap();
    test_cfg_err();
    test_gaps();
    test_len1();
    test_random();
    test_reset_midstream();
`ifdef SEQ_DET_CNT_EN
    test_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
